spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
Parametrised SPI slave front-end for the SPI-RAM subsystem. It deserialises framed commands (2-bit command plus DATA_W payload) from MOSI into a parallel word for the RAM. For read-data commands it waits for the RAM response, then serialises it onto MISO MSB-first. Compared with the fixed 10-bit slave it adds:
- generic payload width
- enforced read-address-before-read-data ordering
- a bounded response timeout
- explicit frame-error reporting

Parameters:
DATA_W, 8, payload bits per frame; frame width W = DATA_W+2.
TIMEOUT, 16, maximum cycles in WAIT_TX before a timeout error; must be >= 1.

Ports:
clk  input  1  SPI/system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
SS_n  input  1  slave select, active low; frame lasts while low.
MOSI  input  1  serial in, MSB of frame first.
MISO  output  1  serial out, registered.
rx_data  output  DATA_W+2  last complete frame {cmd[1:0], payload}.
rx_valid  output  1  one-cycle pulse, rx_data valid.
tx_data  input  DATA_W  RAM read data.
tx_valid  input  1  tx_data valid; sampled only in WAIT_TX.
frame_err  output  1  one-cycle error pulse.
err_code  output  2  01 short frame, 10 read-data without address, 11 timeout; held until next error or reset.
busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at an edge): takes effect at that edge regardless of state.
  - state=IDLE; MISO, rx_valid, rx_data, frame_err, err_code, busy all 0.
  - bit counter, timeout counter and rd_addr_seen cleared.
- Commands: 00 write addr, 01 write data, 10 read addr, 11 read data.
- SS_n sampled high in any non-IDLE state: next state IDLE.
  - If 1 <= bits received < W: frame_err pulse, err_code=01, no rx_valid.
  - SS_n high in WAIT_TX/TX/DONE: silent abort; MISO 0 next edge.
- IDLE: on an edge with SS_n=0, MOSI captured as frame bit W-1, cnt=1, go to RX.
- RX: each edge shifts MOSI in, cnt+1. On the edge capturing bit 0 (cnt reaches W):
  - rx_data updated and rx_valid=1 after that same edge, for exactly one cycle.
  - cmd 10: rd_addr_seen<=1; go to DONE.
  - cmd 00/01: go to DONE; rd_addr_seen unchanged.
  - cmd 11 with rd_addr_seen=1: go to WAIT_TX; timeout counter cleared.
  - cmd 11 with rd_addr_seen=0: rx_valid suppressed (rx_data still updated), frame_err pulse, err_code=10; go to DONE.
- WAIT_TX: the timeout counter increments on each edge in WAIT_TX.
  - tx_valid=1 at edge N: shift<=tx_data, MISO=tx_data[DATA_W-1] after N; rd_addr_seen<=0; go to TX.
  - Counter reaches TIMEOUT: frame_err pulse, err_code=11, rd_addr_seen<=0; go to DONE.
- TX: after edges N+1..N+DATA_W-1, MISO = bits DATA_W-2..0; after edge N+DATA_W, MISO=0 and state=DONE.
- DONE: MOSI ignored; remains until SS_n high, then IDLE.
- Simultaneous SS_n rise and the last RX bit: abort takes priority (short-frame error, no rx_valid).
- MISO is 0 whenever not in TX.

Decomposition:
- Package spi_slave_pkg:
  - state enum {IDLE, RX, WAIT_TX, TX, DONE}
  - command constants CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA
  - error codes ERR_SHORT, ERR_NO_ADDR, ERR_TIMEOUT
- One sub-module: spi_shift_reg (param WIDTH; serial-in/parallel-out and parallel-load/serial-out, sync clear). Instantiated twice: the RX shifter (WIDTH=DATA_W+2) and the TX shifter (WIDTH=DATA_W).

Test Plan:
1. DATA_W=8; SS_n low, send 00_1010_0101 -> rx_valid single pulse after the 10th edge, rx_data=10'h0A5, frame_err=0, MISO=0 throughout.
2. Frame 10_0000_0011, SS_n high, then frame 11_0000_0000; RAM drives tx_data=8'hC3, tx_valid 2 cycles after the second rx_valid -> MISO 1,1,0,0,0,0,1,1 over 8 consecutive edges, then 0, rd_addr_seen=0.
3. After reset, frame 11_1111_1111 -> no rx_valid, frame_err pulse, err_code=10, state DONE until SS_n high.
4. SS_n high after 5 bits -> no rx_valid, frame_err pulse, err_code=01, busy=0 the next cycle.
5. TIMEOUT=4, valid read-addr then read-data, tx_valid never asserted -> frame_err, err_code=11 on the 4th WAIT_TX edge, MISO stays 0.
6. rst=1 for one edge during TX bit 3 -> after that edge MISO=0, busy=0, err_code=0; a new read-data frame then yields err_code=10.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and encodings for the parametrised SPI slave front-end.
package spi_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      WAIT_TX,
      TX,
      DONE
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SHORT   = 2'b01;
   localparam logic [1:0] ERR_NO_ADDR = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Generic shift register: serial-in/parallel-out plus parallel-load/serial-out.
// Shifts toward the MSB; clear has priority over load, load over shift.
module spi_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic             sin,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);

   // Shift/load register with synchronous clear
   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (load)
         q <= din;
      else if (shift)
         q <= {q[WIDTH-2:0], sin};
   end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises {cmd, payload} frames from MOSI, and for
// read-data commands waits for the RAM response and serialises it onto MISO.
// DATA_W must be at least 2.
module spi_slave_param
   import spi_slave_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic              busy
);

   localparam int W  = DATA_W + 2;
   localparam int CW = $clog2(W + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [TW-1:0]     tcnt, tcnt_n;
   logic              rd_addr_seen, rd_addr_seen_n;
   logic [W-1:0]      rx_data_n;
   logic              rx_valid_n;
   logic              frame_err_n;
   logic [1:0]        err_code_n;
   logic              miso_n;

   logic              rx_shift;
   logic              tx_load;
   logic              tx_shift;
   logic [W-1:0]      rx_q;
   logic [DATA_W-1:0] tx_q;
   logic [W-1:0]      rx_word;

   spi_shift_reg #(.WIDTH(W)) u_rx_shift (
      .clk   (clk),
      .clr   (rst),
      .load  (1'b0),
      .shift (rx_shift),
      .sin   (MOSI),
      .din   ('0),
      .q     (rx_q)
   );

   spi_shift_reg #(.WIDTH(DATA_W)) u_tx_shift (
      .clk   (clk),
      .clr   (rst),
      .load  (tx_load),
      .shift (tx_shift),
      .sin   (1'b0),
      .din   (tx_data),
      .q     (tx_q)
   );

   // MISO is registered, so it always takes the bit one below the shifter's
   // current MSB; the shifter's MSB and the RX shifter's oldest bit are never read.
   logic unused_bits;
   assign unused_bits = ^{rx_q[W-1], tx_q[DATA_W-1]};

   assign busy = (state != IDLE);

   // Next-state and next-output decode; abort on SS_n high beats everything
   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      tcnt_n         = tcnt;
      rd_addr_seen_n = rd_addr_seen;
      rx_data_n      = rx_data;
      rx_valid_n     = 1'b0;
      frame_err_n    = 1'b0;
      err_code_n     = err_code;
      miso_n         = 1'b0;
      rx_shift       = 1'b0;
      tx_load        = 1'b0;
      tx_shift       = 1'b0;
      rx_word        = {rx_q[W-2:0], MOSI};

      if (state != IDLE && SS_n) begin
         state_n = IDLE;
         cnt_n   = '0;
         if (state == RX) begin
            frame_err_n = 1'b1;
            err_code_n  = ERR_SHORT;
         end
      end else begin
         case (state)
            IDLE: begin
               if (!SS_n) begin
                  rx_shift = 1'b1;
                  cnt_n    = CW'(1);
                  state_n  = RX;
               end
            end
            RX: begin
               rx_shift = 1'b1;
               if (cnt == CW'(W - 1)) begin
                  cnt_n     = '0;
                  rx_data_n = rx_word;
                  case (rx_word[W-1 -: 2])
                     CMD_WR_ADDR, CMD_WR_DATA: begin
                        rx_valid_n = 1'b1;
                        state_n    = DONE;
                     end
                     CMD_RD_ADDR: begin
                        rx_valid_n     = 1'b1;
                        rd_addr_seen_n = 1'b1;
                        state_n        = DONE;
                     end
                     CMD_RD_DATA: begin
                        if (rd_addr_seen) begin
                           rx_valid_n = 1'b1;
                           tcnt_n     = '0;
                           state_n    = WAIT_TX;
                        end else begin
                           frame_err_n = 1'b1;
                           err_code_n  = ERR_NO_ADDR;
                           state_n     = DONE;
                        end
                     end
                  endcase
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            WAIT_TX: begin
               if (tx_valid) begin
                  tx_load        = 1'b1;
                  miso_n         = tx_data[DATA_W-1];
                  rd_addr_seen_n = 1'b0;
                  cnt_n          = '0;
                  state_n        = TX;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  frame_err_n    = 1'b1;
                  err_code_n     = ERR_TIMEOUT;
                  rd_addr_seen_n = 1'b0;
                  tcnt_n         = '0;
                  state_n        = DONE;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            TX: begin
               tx_shift = 1'b1;
               if (cnt == CW'(DATA_W - 1)) begin
                  cnt_n   = '0;
                  state_n = DONE;
               end else begin
                  cnt_n  = cnt + 1'b1;
                  miso_n = tx_q[DATA_W-2];
               end
            end
            DONE: begin
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         tcnt         <= '0;
         rd_addr_seen <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         err_code     <= ERR_NONE;
         MISO         <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         tcnt         <= tcnt_n;
         rd_addr_seen <= rd_addr_seen_n;
         rx_data      <= rx_data_n;
         rx_valid     <= rx_valid_n;
         frame_err    <= frame_err_n;
         err_code     <= err_code_n;
         MISO         <= miso_n;
      end
   end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: scenario tasks derive the expected
// per-cycle outputs from the frame rules; one process compares every cycle.
module tb_spi_slave_param;

   localparam int DW   = 8;
   localparam int W    = DW + 2;
   localparam int TOUT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic [W-1:0]  rx_data;
   logic          rx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          frame_err;
   logic [1:0]    err_code;
   logic          busy;

   always #5 clk = ~clk;

   spi_slave_param #(.DATA_W(DW), .TIMEOUT(TOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .frame_err (frame_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   int checks   = 0;
   int failures = 0;

   // expected values for the cycle after the coming edge
   logic         e_miso, e_rxv, e_fe, e_busy;
   // frame-level model state
   logic [1:0]   m_err;
   logic [W-1:0] m_rxd;
   bit           m_seen;
   bit           cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle comparison, sampled 2 time units after the active edge
   always @(posedge clk) begin
      #2;
      if (cmp_en) begin
         chk("MISO", MISO, e_miso);
         chk("rx_valid", rx_valid, e_rxv);
         chk("frame_err", frame_err, e_fe);
         chk("busy", busy, e_busy);
         chk("err_code", err_code, m_err);
         chk("rx_data", rx_data, m_rxd);
      end
   end

   // drive inputs and expectations for one edge, then wait to the next negedge
   task automatic tick(input logic ss, input logic mosi, input logic txv,
                       input logic [DW-1:0] txd, input logic r,
                       input logic em, input logic erv, input logic efe, input logic eb);
      SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd; rst = r;
      e_miso = em; e_rxv = erv; e_fe = efe; e_busy = eb;
      cmp_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset(input logic ss);
      m_seen = 1'b0; m_err = 2'b00; m_rxd = '0;
      tick(ss, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic release_ss();
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++)
         tick(1'b0, 1'($urandom_range(1)), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // send nbits of {cmd, payload} MSB first; a short frame is closed with SS_n high
   task automatic send_frame(input logic [1:0] cmd, input logic [DW-1:0] pl, input int nbits);
      logic [W-1:0] f;
      f = {cmd, pl};
      for (int i = 0; i < nbits; i++) begin
         if (i == W - 1) begin
            m_rxd = f;
            if (cmd == 2'b11 && !m_seen) begin
               m_err = 2'b10;
               tick(1'b0, f[0], 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
               if (cmd == 2'b10) m_seen = 1'b1;
               tick(1'b0, f[0], 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            end
         end else begin
            tick(1'b0, f[W-1-i], 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
      end
      if (nbits < W) begin
         if (nbits >= 1) m_err = 2'b01;
         tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, (nbits >= 1), 1'b0);
      end
   endtask

   // RAM answers after 'delay' idle cycles; collects the serialised bits
   task automatic wait_tx(input int delay, input logic [DW-1:0] d, output logic [DW-1:0] got);
      for (int i = 0; i < delay; i++)
         tick(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      m_seen = 1'b0;
      tick(1'b0, 1'b0, 1'b1, d, 1'b0, d[DW-1], 1'b0, 1'b0, 1'b1);
      got[DW-1] = MISO;
      for (int b = DW - 2; b >= 0; b--) begin
         tick(1'b0, 1'b0, 1'b0, '0, 1'b0, d[b], 1'b0, 1'b0, 1'b1);
         got[b] = MISO;
      end
      tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic timeout_wait();
      for (int k = 1; k <= TOUT; k++) begin
         if (k == TOUT) begin
            m_err = 2'b11; m_seen = 1'b0;
            tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         end else begin
            tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
      end
   endtask

   initial begin
      logic [DW-1:0] got;
      logic [DW-1:0] d6;
      SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0; rst = 1'b1;

      do_reset(1'b1);
      chk("reset_err_code", err_code, 2'b00);
      chk("reset_busy", busy, 1'b0);

      // 1: write-address frame
      send_frame(2'b00, 8'hA5, W);
      chk("t1_rx_data", rx_data, 10'h0A5);
      hold(2);
      release_ss();

      // 2: read address, then read data answered with C3
      send_frame(2'b10, 8'h03, W);
      release_ss();
      send_frame(2'b11, 8'h00, W);
      wait_tx(1, 8'hC3, got);
      chk("t2_miso_bits", got, 8'hC3);
      hold(2);
      release_ss();
      // address flag consumed: another read-data is an ordering error
      send_frame(2'b11, 8'h55, W);
      chk("t2_addr_consumed", err_code, 2'b10);
      release_ss();

      // 3: read-data without address after reset
      do_reset(1'b1);
      send_frame(2'b11, 8'hFF, W);
      hold(3);
      chk("t3_err_code", err_code, 2'b10);
      chk("t3_done_busy", busy, 1'b1);
      release_ss();

      // 4: short frame of 5 bits
      send_frame(2'b01, 8'hF0, 5);
      chk("t4_err_code", err_code, 2'b01);

      // full write-data frame, then SS_n rising together with the last bit
      send_frame(2'b01, 8'h5E, W);
      release_ss();
      send_frame(2'b00, 8'h3C, W - 1);
      chk("abort_last_bit_err", err_code, 2'b01);

      // 5: timeout
      send_frame(2'b10, 8'h12, W);
      release_ss();
      send_frame(2'b11, 8'h00, W);
      timeout_wait();
      hold(2);
      chk("t5_err_code", err_code, 2'b11);
      release_ss();

      // silent abort while waiting for RAM
      send_frame(2'b10, 8'h34, W);
      release_ss();
      send_frame(2'b11, 8'h00, W);
      tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      release_ss();
      chk("wait_abort_err_kept", err_code, 2'b11);

      // 6: reset during TX bit 3
      do_reset(1'b1);
      send_frame(2'b10, 8'h01, W);
      release_ss();
      send_frame(2'b11, 8'h00, W);
      d6 = 8'hA6;
      m_seen = 1'b0;
      tick(1'b0, 1'b0, 1'b1, d6, 1'b0, d6[7], 1'b0, 1'b0, 1'b1);
      for (int b = 6; b >= 4; b--)
         tick(1'b0, 1'b0, 1'b0, '0, 1'b0, d6[b], 1'b0, 1'b0, 1'b1);
      do_reset(1'b0);
      chk("t6_miso", MISO, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_err_code", err_code, 2'b00);
      send_frame(2'b11, 8'h0F, W);
      chk("t6_no_addr", err_code, 2'b10);
      release_ss();
      hold(0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
